// File: rtl/por_seq_ctrl.sv
// Power-on reset sequencer: synchronises and debounces reset requests and power-good,
// then releases downstream resets in order (or all at once) with a programmable gap.
module por_seq_ctrl #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8,
    parameter int DLY_W       = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NCH-1:0]   por_in,
    input  logic             pgood_i,
    input  logic [DEB_W-1:0] deb_len,
    input  logic [DLY_W-1:0] dly_len,
    input  logic             mode,
    input  logic             fault_clr_i,
    output logic [NCH-1:0]   rst_o,
    output logic             seq_done_o,
    output logic [1:0]       status_o,
    output logic             fault_o
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'b00,
        S_RELEASE = 2'b01,
        S_RUN     = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0][NCH-1:0] r_por_sync;
    logic [SYNC_STAGES-1:0]          r_pg_sync;
    logic [DEB_W-1:0]                r_por_cnt [NCH];
    logic [NCH-1:0]                  r_por_deb;
    logic [DEB_W-1:0]                r_pg_cnt;
    logic                            r_pg_deb;

    state_t            r_state, w_state_nxt;
    logic [NCH-1:0]    r_rst, w_rst_nxt;
    logic [DLY_W-1:0]  r_dcnt, w_dcnt_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              r_mode, w_mode_nxt;
    logic              r_done;
    logic              r_fault;

    logic [NCH-1:0]    w_por_s;
    logic              w_pg_s;
    logic              w_hold_req;
    logic              w_pg_fall;

    assign w_por_s    = r_por_sync[SYNC_STAGES-1];
    assign w_pg_s     = r_pg_sync[SYNC_STAGES-1];
    assign w_hold_req = (|r_por_deb) | ~r_pg_deb;
    // True on the edge where the debounced power-good flips to 0.
    assign w_pg_fall  = r_pg_deb & ~w_pg_s & (r_pg_cnt == deb_len);

    // Synchronisers and debouncers; reset values request HOLD.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_por_sync <= '1;
            r_pg_sync  <= '0;
            for (int i = 0; i < NCH; i++) r_por_cnt[i] <= '0;
            r_por_deb  <= '1;
            r_pg_cnt   <= '0;
            r_pg_deb   <= 1'b0;
        end else begin
            r_por_sync <= {r_por_sync[SYNC_STAGES-2:0], por_in};
            r_pg_sync  <= {r_pg_sync[SYNC_STAGES-2:0], pgood_i};
            for (int i = 0; i < NCH; i++) begin
                if (w_por_s[i] == r_por_deb[i]) begin
                    r_por_cnt[i] <= '0;
                end else if (r_por_cnt[i] == deb_len) begin
                    r_por_deb[i] <= w_por_s[i];
                    r_por_cnt[i] <= '0;
                end else begin
                    r_por_cnt[i] <= r_por_cnt[i] + 1'b1;
                end
            end
            if (w_pg_s == r_pg_deb) begin
                r_pg_cnt <= '0;
            end else if (r_pg_cnt == deb_len) begin
                r_pg_deb <= w_pg_s;
                r_pg_cnt <= '0;
            end else begin
                r_pg_cnt <= r_pg_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_HOLD;
            r_rst   <= '1;
            r_dcnt  <= '0;
            r_idx   <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rst   <= w_rst_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_idx   <= w_idx_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= (w_state_nxt == S_RUN);
            // A new brown-out beats a simultaneous clear request.
            if (w_pg_fall && (r_state == S_RELEASE || r_state == S_RUN))
                r_fault <= 1'b1;
            else if (fault_clr_i)
                r_fault <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rst_nxt   = r_rst;
        w_dcnt_nxt  = r_dcnt;
        w_idx_nxt   = r_idx;
        w_mode_nxt  = r_mode;
        if (w_hold_req) begin
            w_state_nxt = S_HOLD;
            w_rst_nxt   = '1;
            w_dcnt_nxt  = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_state_nxt = S_RELEASE;
                    w_rst_nxt   = '1;
                    w_dcnt_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_mode_nxt  = mode;
                end
                S_RELEASE: begin
                    if (r_dcnt == dly_len) begin
                        w_dcnt_nxt = '0;
                        if (r_mode) begin
                            w_rst_nxt   = '0;
                            w_state_nxt = S_RUN;
                        end else begin
                            w_rst_nxt[r_idx] = 1'b0;
                            w_idx_nxt        = r_idx + 1'b1;
                            if (r_idx == IDX_LAST) w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_dcnt_nxt = r_dcnt + 1'b1;
                    end
                end
                S_RUN: begin
                    w_rst_nxt = '0;
                end
                default: begin
                    w_state_nxt = S_HOLD;
                    w_rst_nxt   = '1;
                end
            endcase
        end
    end

    assign rst_o      = r_rst;
    assign seq_done_o = r_done;
    assign status_o   = r_state;
    assign fault_o    = r_fault;

endmodule

// File: tb/tb_por_seq_ctrl.sv
// Directed bench for por_seq_ctrl: qualification latency, ordered/simultaneous release,
// glitch rejection, brown-out fault handling and mid-sequence reset.
module tb_por_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  por_in;
    logic        pgood;
    logic [7:0]  deb_len;
    logic [15:0] dly_len;
    logic        mode;
    logic        fault_clr;
    logic [3:0]  rst_o;
    logic        seq_done;
    logic [1:0]  status;
    logic        fault;

    int n_vec  = 0;
    int n_fail = 0;

    por_seq_ctrl #(.NCH(4), .SYNC_STAGES(2), .DEB_W(8), .DLY_W(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .por_in      (por_in),
        .pgood_i     (pgood),
        .deb_len     (deb_len),
        .dly_len     (dly_len),
        .mode        (mode),
        .fault_clr_i (fault_clr),
        .rst_o       (rst_o),
        .seq_done_o  (seq_done),
        .status_o    (status),
        .fault_o     (fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called one step after RELEASE entry; walks the release steps with gap-cycle spacing.
    task automatic seq_check(input logic m, input int gap);
        logic [3:0] exp;
        int nrel;
        exp  = 4'b1111;
        nrel = m ? 1 : 4;
        for (int k = 0; k < nrel; k++) begin
            tick(gap - 1);
            check("pre_release", rst_o, exp);
            tick(1);
            exp = m ? 4'b0000 : (exp << 1);
            check("release", rst_o, exp);
        end
        check("run_status", status, 2'b10);
        check("run_done", seq_done, 1'b1);
    endtask

    // From RUN: 6-cycle request on channel ch forces HOLD, then the request drops.
    task automatic hold_cycle(input int ch);
        por_in[ch] = 1'b1;
        tick(6);
        check("hold_not_yet", status, 2'b10);
        por_in[ch] = 1'b0;
        tick(1);
        check("hold_rst", rst_o, 4'b1111);
        check("hold_status", status, 2'b00);
        check("hold_nofault", fault, 1'b0);
        tick(5);
        check("requal_hold", status, 2'b00);
        tick(1);
        check("requal_release", status, 2'b01);
    endtask

    initial begin
        rst = 1'b1; por_in = 4'b0000; pgood = 1'b1; deb_len = 8'd3; dly_len = 16'd5;
        mode = 1'b0; fault_clr = 1'b0;
        tick(2);
        check("rst_rst_o", rst_o, 4'b1111);
        check("rst_status", status, 2'b00);
        check("rst_done", seq_done, 1'b0);
        check("rst_fault", fault, 1'b0);
        rst = 1'b0;
        tick(6);
        check("qual_hold", status, 2'b00);
        tick(1);
        check("qual_release", status, 2'b01);
        check("qual_rst", rst_o, 4'b1111);
        seq_check(1'b0, 6);

        // Short request glitch is rejected.
        por_in[2] = 1'b1;
        tick(3);
        por_in[2] = 1'b0;
        tick(8);
        check("glitch_status", status, 2'b10);
        check("glitch_rst", rst_o, 4'b0000);

        hold_cycle(2);
        seq_check(1'b0, 6);

        // Brown-out in RUN.
        pgood = 1'b0;
        tick(5);
        check("bo_fault_pre", fault, 1'b0);
        tick(1);
        check("bo_fault_set", fault, 1'b1);
        tick(1);
        check("bo_rst", rst_o, 4'b1111);
        check("bo_status", status, 2'b00);
        tick(3);
        pgood = 1'b1;
        tick(6);
        check("bo_hold", status, 2'b00);
        tick(1);
        check("bo_release", status, 2'b01);
        seq_check(1'b0, 6);
        check("bo_fault_sticky", fault, 1'b1);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check("fault_cleared", fault, 1'b0);

        // Simultaneous release; a mode change during RELEASE is ignored.
        mode = 1'b1;
        hold_cycle(0);
        mode = 1'b0;
        seq_check(1'b1, 6);

        // Synchronous reset after two channels are released.
        hold_cycle(1);
        tick(12);
        check("mid_two_released", rst_o, 4'b1100);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_rst_o", rst_o, 4'b1111);
        check("mid_rst_status", status, 2'b00);
        tick(6);
        check("mid_requal_hold", status, 2'b00);
        tick(1);
        check("mid_requal_release", status, 2'b01);
        seq_check(1'b0, 6);

        // Zero inter-stage delay.
        dly_len = 16'd0;
        hold_cycle(3);
        seq_check(1'b0, 1);

        // Fault set beats a same-cycle clear.
        pgood = 1'b0;
        tick(5);
        check("sw_fault_pre", fault, 1'b0);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check("set_wins", fault, 1'b1);
        pgood = 1'b1;
        tick(2);
        check("sw_hold", status, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
